// File: rtl/zero_flag_pipe.sv
// zero_flag_pipe: pipelined FANIN-ary zero detect feeding the NZCV flag register.
// Define FLAGS_BYPASS_EN to forward the next-state NZCV onto out_flags.
module zero_flag_pipe #(
    parameter int  WIDTH       = 64,
    parameter int  FANIN       = 4,
    parameter int  STAGE_EVERY = 1,
    parameter real DELAY       = 0.05
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             advance,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_set_flags,
    input  logic [2:0]       in_ncv,
    output logic             out_valid,
    output logic             out_zero,
    output logic [3:0]       out_flags,
    output logic             out_flags_wr
);

    function automatic int calcLevels(input int w, input int f);
        int n;
        int l;
        n = 1;
        l = 0;
        while (n < w) begin
            n = n * f;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = calcLevels(WIDTH, FANIN);
    localparam int SE     = (STAGE_EVERY > 0) ? STAGE_EVERY : 1;

    if (WIDTH < 2 || FANIN < 2 || FANIN > 8 || STAGE_EVERY < 0 || DELAY < 0.0)
    begin : gBadParam
        $error("zero_flag_pipe: illegal parameter set");
    end

    // Level 0 is the padded input; level LEVELS is the final NOR.
    for (genvar l = 0; l <= LEVELS; l++) begin : gLvl
        localparam int NODES = FANIN ** (LEVELS - l);
        localparam bit REGD  = (l > 0) && (STAGE_EVERY > 0) &&
                               ((l % SE == 0) || (l == LEVELS));

        logic [NODES-1:0] val;
        logic             vld;
        logic             setF;
        logic [2:0]       ncv;

        if (l == 0) begin : gIn
            assign val  = NODES'(in_data);
            assign vld  = in_valid;
            assign setF = in_set_flags;
            assign ncv  = in_ncv;
        end else begin : gTree
            logic [NODES-1:0] node;

            for (genvar j = 0; j < NODES; j++) begin : gNode
                if (l == LEVELS) begin : gNor
                    assign node[j] = ~|gLvl[l-1].val[j*FANIN +: FANIN];
                end else begin : gOr
                    assign node[j] = |gLvl[l-1].val[j*FANIN +: FANIN];
                end
            end

            if (REGD) begin : gReg
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        vld  <= 1'b0;
                        val  <= '0;
                        setF <= 1'b0;
                        ncv  <= '0;
                    end else begin
                        if (flush) begin
                            vld <= 1'b0;
                        end else if (advance) begin
                            vld <= gLvl[l-1].vld;
                        end
                        if (advance) begin
                            val  <= node;
                            setF <= gLvl[l-1].setF;
                            ncv  <= gLvl[l-1].ncv;
                        end
                    end
                end
            end else begin : gComb
                assign val  = node;
                assign vld  = gLvl[l-1].vld;
                assign setF = gLvl[l-1].setF;
                assign ncv  = gLvl[l-1].ncv;
            end
        end
    end

    logic [3:0] nzcv;
    logic [3:0] nzcvNext;
    logic [2:0] lastNcv;
    logic       lastSetF;
    logic       flagsWr;

    assign out_valid = gLvl[LEVELS].vld;
    assign out_zero  = gLvl[LEVELS].val[0];
    assign lastSetF  = gLvl[LEVELS].setF;
    assign lastNcv   = gLvl[LEVELS].ncv;

    assign flagsWr      = out_valid & lastSetF & advance & ~flush;
    assign out_flags_wr = flagsWr;
    assign nzcvNext     = {lastNcv[2], out_zero, lastNcv[1], lastNcv[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv <= 4'b0000;
        end else if (flagsWr) begin
            nzcv <= nzcvNext;
        end
    end

`ifdef FLAGS_BYPASS_EN
    assign out_flags = flagsWr ? nzcvNext : nzcv;
`else
    assign out_flags = nzcv;
`endif

endmodule

// File: tb/tb_zero_flag_pipe.sv
// Directed bench for zero_flag_pipe: 64/4/1 (LAT=3), 16/2/1 (LAT=4), 64/4/0 (LAT=0).
module tb_zero_flag_pipe;

`ifdef FLAGS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        advance;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_set_flags;
    logic [2:0]  in_ncv;

    logic       v, z, w;
    logic [3:0] f;
    logic       v2, z2, w2;
    logic [3:0] f2;
    logic       v0, z0, w0;
    logic [3:0] f0;

    int checks = 0;
    int errors = 0;
    int validCount;

    zero_flag_pipe #(.WIDTH(64), .FANIN(4), .STAGE_EVERY(1)) dut (
        .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_set_flags(in_set_flags),
        .in_ncv(in_ncv), .out_valid(v), .out_zero(z), .out_flags(f),
        .out_flags_wr(w)
    );

    zero_flag_pipe #(.WIDTH(16), .FANIN(2), .STAGE_EVERY(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[15:0]),
        .in_set_flags(in_set_flags), .in_ncv(in_ncv), .out_valid(v2),
        .out_zero(z2), .out_flags(f2), .out_flags_wr(w2)
    );

    zero_flag_pipe #(.WIDTH(64), .FANIN(4), .STAGE_EVERY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_set_flags(in_set_flags),
        .in_ncv(in_ncv), .out_valid(v0), .out_zero(z0), .out_flags(f0),
        .out_flags_wr(w0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chkB(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkF(input string tag, input logic [3:0] got,
                        input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkI(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_data      = '0;
        in_set_flags = 1'b0;
        in_ncv       = '0;
        advance      = 1'b1;
        flush        = 1'b0;
    endtask

    task automatic issue(input logic [63:0] d, input logic sf,
                         input logic [2:0] n);
        in_valid     = 1'b1;
        in_data      = d;
        in_set_flags = sf;
        in_ncv       = n;
        advance      = 1'b1;
        flush        = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        idle();
        #2 reset_n = 1'b0;

        // reset held while inputs are active
        for (int t = 0; t < 4; t++) begin
            cyc();
            issue(64'(t), 1'b1, 3'b111);
            mid();
            chkB("rst_valid", v, 1'b0);
            chkB("rst_zero", z, 1'b0);
            chkB("rst_wr", w, 1'b0);
            chkF("rst_flags", f, 4'b0000);
            chkB("rst_valid16", v2, 1'b0);
        end
        cyc();
        idle();
        reset_n = 1'b1;
        mid();
        chkB("rel_valid", v, 1'b0);

        // A: zero result, set flags, ncv=010
        for (int t = 0; t < 6; t++) begin
            cyc();
            if (t == 0) issue(64'h0, 1'b1, 3'b010);
            else idle();
            mid();
            chkB("A_valid", v, t == 3);
            if (t == 3) chkB("A_zero", z, 1'b1);
            chkB("A_wr", w, t == 3);
            chkF("A_flags", f, (t >= 4 || (t == 3 && BYP)) ? 4'b0110 : 4'b0000);
            chkB("A0_valid", v0, t == 0);
            if (t == 0) chkB("A0_zero", z0, 1'b1);
            chkF("A0_flags", f0, (t >= 1 || BYP) ? 4'b0110 : 4'b0000);
            chkB("A2_valid", v2, t == 4);
            if (t == 4) chkB("A2_zero", z2, 1'b1);
            chkB("A2_wr", w2, t == 4);
            chkF("A2_flags", f2, (t >= 5 || (t == 4 && BYP)) ? 4'b0110 : 4'b0000);
        end

        // B: only the MSB set; the 16-bit instance sees zero
        for (int t = 0; t < 6; t++) begin
            cyc();
            if (t == 0) issue(64'h8000_0000_0000_0000, 1'b1, 3'b101);
            else idle();
            mid();
            chkB("B_valid", v, t == 3);
            if (t == 3) chkB("B_zero", z, 1'b0);
            chkF("B_flags", f, (t >= 4 || (t == 3 && BYP)) ? 4'b1001 : 4'b0110);
            chkB("B0_valid", v0, t == 0);
            if (t == 0) chkB("B0_zero", z0, 1'b0);
            chkF("B0_flags", f0, (t >= 1 || BYP) ? 4'b1001 : 4'b0110);
            chkB("B2_valid", v2, t == 4);
            if (t == 4) chkB("B2_zero", z2, 1'b1);
            chkF("B2_flags", f2, (t >= 5 || (t == 4 && BYP)) ? 4'b1101 : 4'b0110);
        end

        // C: non flag-setting op leaves NZCV alone
        for (int t = 0; t < 5; t++) begin
            cyc();
            if (t == 0) issue(64'h0, 1'b0, 3'b111);
            else idle();
            mid();
            chkB("C_valid", v, t == 3);
            if (t == 3) chkB("C_zero", z, 1'b1);
            chkB("C_wr", w, 1'b0);
            chkF("C_flags", f, 4'b1001);
        end

        // walking one, back to back
        validCount = 0;
        for (int t = 0; t < 68; t++) begin
            cyc();
            if (t < 64) issue(64'd1 << t, 1'b0, 3'b000);
            else idle();
            mid();
            if (v) validCount++;
            chkB("W_valid", v, t >= 3 && t < 67);
            if (t >= 3 && t < 67) chkB("W_zero", z, 1'b0);
            chkB("W2_valid", v2, t >= 4 && t < 68);
            if (t >= 4 && t < 68) chkB("W2_zero", z2, (t - 4) >= 16);
            chkB("W0_valid", v0, t < 64);
            if (t < 64) chkB("W0_zero", z0, 1'b0);
        end
        chkI("W_count", validCount, 64);
        chkF("W_flags", f, 4'b1001);

        // stall while the op is inside the pipe
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (t == 0) issue(64'h0, 1'b1, 3'b001);
            else idle();
            advance = !(t >= 1 && t <= 5);
            mid();
            chkB("S1_valid", v, t == 8);
            if (t == 8) chkB("S1_zero", z, 1'b1);
            chkB("S1_wr", w, t == 8);
            chkF("S1_flags", f, (t >= 9 || (t == 8 && BYP)) ? 4'b0101 : 4'b1001);
        end

        // stall while the op sits at the output
        for (int t = 0; t < 9; t++) begin
            cyc();
            if (t == 0) issue(64'h10, 1'b1, 3'b110);
            else idle();
            advance = !(t >= 3 && t <= 5);
            mid();
            chkB("S2_valid", v, t >= 3 && t <= 6);
            if (t >= 3 && t <= 6) chkB("S2_zero", z, 1'b0);
            chkB("S2_wr", w, t == 6);
            chkF("S2_flags", f, (t >= 7 || (t == 6 && BYP)) ? 4'b1010 : 4'b0101);
        end

        // flush kills three in-flight ops; the next op still flows
        for (int t = 0; t < 8; t++) begin
            cyc();
            if (t <= 3) issue(64'h0, 1'b1, (t == 3) ? 3'b011 : 3'b111);
            else idle();
            flush = (t == 2);
            mid();
            chkB("F1_valid", v, t == 6);
            if (t == 6) chkB("F1_zero", z, 1'b1);
            chkB("F1_wr", w, t == 6);
            chkF("F1_flags", f, (t >= 7 || (t == 6 && BYP)) ? 4'b0111 : 4'b1010);
        end

        // flush the op that is at the output
        for (int t = 0; t < 6; t++) begin
            cyc();
            if (t == 0) issue(64'h0, 1'b1, 3'b100);
            else idle();
            flush = (t == 3);
            mid();
            chkB("F2_valid", v, t == 3);
            chkB("F2_wr", w, 1'b0);
            chkF("F2_flags", f, 4'b0111);
        end

        // flush during a stall still clears the op
        for (int t = 0; t < 6; t++) begin
            cyc();
            if (t == 0) issue(64'h0, 1'b1, 3'b100);
            else idle();
            if (t == 1) begin
                advance = 1'b0;
                flush   = 1'b1;
            end
            mid();
            chkB("F3_valid", v, 1'b0);
            chkF("F3_flags", f, 4'b0111);
        end

        // asynchronous reset mid-pipeline
        cyc();
        issue(64'h0, 1'b1, 3'b111);
        cyc();
        idle();
        #2 reset_n = 1'b0;
        #2;
        chkB("R_valid", v, 1'b0);
        chkB("R_wr", w, 1'b0);
        chkF("R_flags", f, 4'b0000);
        chkB("R2_valid", v2, 1'b0);
        for (int t = 0; t < 5; t++) begin
            cyc();
            if (t == 0) reset_n = 1'b1;
            idle();
            mid();
            chkB("R_post_valid", v, 1'b0);
            chkF("R_post_flags", f, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
